mul_seq_ctrl: RTL
=================

# mul_seq_ctrl

Sequential unsigned shift-add multiplier controller. It accepts an operand pair over a valid/ready handshake and sequences one partial-product accumulation per clock, one bit of `b` per step. It returns the exact 2·WIDTH-bit product over a second valid/ready handshake. It is the multi-cycle, width-scalable counterpart to the combinational 2-bit multiplier, and sits between an operand producer and a result consumer.

## Interface
- `WIDTH`, default 4: operand width in bits. Legal range is 2..32.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start_valid`  in  1: operand pair on `a`/`b` is valid.
- `start_ready`  out  1: block can accept operands. High only in IDLE.
- `a`  in  WIDTH: multiplicand, unsigned.
- `b`  in  WIDTH: multiplier, unsigned.
- `p_valid`  out  1: product on `p` is valid.
- `p_ready`  in  1: consumer accepts the product.
- `p`  out  2·WIDTH: product a·b.
- `busy`  out  1: high in CALC or DONE.

## Operation
- **FSM states:** IDLE, CALC, DONE. Encoded as a 2-bit enum.
- **IDLE:**
  - `start_ready`=1.
  - On `start_valid && start_ready`: latch `a` into `mcand` (zero-extended to 2·WIDTH), latch `b` into `mplier`, clear `acc` and `cnt`, go to CALC.
- **CALC, one step per cycle:**
  - If `mplier[0]`, then `acc <= acc + mcand`.
  - `mcand <= mcand << 1`, `mplier <= mplier >> 1`, `cnt <= cnt + 1`.
  - After the step with `cnt == WIDTH-1`, go to DONE.
- **Step count:** exactly WIDTH steps. There is no early exit on a zero multiplier, so latency is fixed.
- **DONE:**
  - `p_valid`=1 and `p`=`acc`.
  - `p` stays stable until `p_valid && p_ready`, then return to IDLE.
- **Arithmetic:**
  - Unsigned. `acc` is 2·WIDTH bits and never overflows, since the maximum product is (2^W−1)² < 2^(2W).
  - `cnt` width is $clog2(WIDTH+1).
- **Input sampling:**
  - `a`/`b` are sampled only on the start handshake. Changes afterwards have no effect.
  - `start_valid` while busy is ignored and not queued. The producer holds it until `start_ready`.
- **No bypass:** a start handshake cannot happen in the cycle a result is accepted. `start_ready` rises the cycle after the result handshake.
- **Backpressure:** `p_ready` held low leaves the block in DONE indefinitely. `p` and `p_valid` hold.
- **Reset:**
  - Asserting `rst` at any time, including mid-CALC or in DONE, aborts the operation.
  - The state goes to IDLE and all datapath registers clear immediately (asynchronously).

## Timing
- **Reset values:** `start_ready`=1, `p_valid`=0, `p`=0, `busy`=0.
- **Cycle numbering:** cycle 0 is the start handshake edge.
- **CALC:** occupies cycles 1..WIDTH, with `busy`=1 from cycle 1.
- **DONE:** `p_valid` rises at cycle WIDTH+1.
  - If `p_ready`=1 at that edge, the result is accepted and `start_ready`=1 from cycle WIDTH+2.
- **Throughput:** minimum initiation interval is WIDTH+2 cycles.
- **Output drive:** all outputs are decoded from registered state and datapath. No combinational path from inputs to outputs.

## Structure
- **Package `mul_pkg`:** state enum (`S_IDLE`, `S_CALC`, `S_DONE`) and a `MUL_WIDTH_DEFAULT`=4 constant.
- **Sub-module `mul_shift_add_dp`:** `mcand`/`mplier`/`acc`/`cnt` registers, with `load`/`step` controls and a `last` flag out.
- **`mul_seq_ctrl`:** holds the FSM and handshake logic and instantiates `mul_shift_add_dp`.

## Test plan
- **Basic product:** WIDTH=4, a=3, b=2, `p_ready`=1 → `p_valid` at cycle 5, `p`=6, `start_ready` high at cycle 6.
- **Max operands:** WIDTH=4, a=15, b=15 → `p`=225 (0xE1). WIDTH=2, a=3, b=3 → `p`=9.
- **Zero operands:** a=0, b=9 and a=9, b=0 → `p`=0, with latency still WIDTH+1.
- **Backpressure:** hold `p_ready`=0 for 10 cycles after `p_valid` → `p`, `p_valid` and `busy` stable. Toggle `a`, `b` and `start_valid` meanwhile → no effect. Release `p_ready` → one acceptance, then IDLE.
- **Reset mid-operation:** assert `rst` at cycle 2 of a=7, b=5 → `busy`=0, `p`=0, `p_valid`=0 immediately. After deassertion, a=7, b=5 → `p`=35.
- **Exhaustive back-to-back:** all 256 (a,b) pairs at WIDTH=4, `start_valid` held high and random `p_ready`. Each `p` equals a·b, results arrive in order with none lost or duplicated, and the interval is ≥ 6 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types for the sequential shift-add multiplier.
// Holds the controller state encoding and default operand width.
package mul_pkg;

  localparam int MUL_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: one partial product per step.
// Holds mcand/mplier/acc/cnt and flags the final step.
module mul_shift_add_dp
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  // asserted during the step that consumes the top multiplier bit
  assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned multiplier: start/product handshakes
// around a fixed-latency shift-add datapath.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               p_valid,
  input  logic               p_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  state_t             state;
  state_t             nxt;
  logic               load;
  logic               step;
  logic               last;
  logic [2*WIDTH-1:0] acc;

  mul_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    (a),
    .b    (b),
    .acc  (acc),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt  = state;
    load = 1'b0;
    step = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_valid) begin
          load = 1'b1;
          nxt  = S_CALC;
        end
      end
      S_CALC: begin
        step = 1'b1;
        if (last) begin
          nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (p_ready) begin
          nxt = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // outputs depend only on registered state and acc
  assign start_ready = (state == S_IDLE);
  assign p_valid     = (state == S_DONE);
  assign busy        = (state == S_CALC) || (state == S_DONE);
  assign p           = acc;

endmodule
